// File: rtl/mem_seq_unit.sv
// Multi-cycle fetch/execute/memory sequencer: owns the PC, serialises each
// instruction into phases, emits one commit pulse per retired instruction and
// traps on halt or memory timeout.
module mem_seq_unit #(
  parameter int unsigned        ADDR_W  = 32,
  parameter logic [ADDR_W-1:0]  PC_INIT = '0,
  parameter int unsigned        TIMEOUT = 255,
  parameter int unsigned        CNT_W   = 8,
  parameter int unsigned        RET_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [31:0]       imemload,
  output logic              imemREN,
  output logic [ADDR_W-1:0] imemaddr,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              dreq_rd,
  input  logic              dreq_wr,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              dhit,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              commit,
  output logic              halt,
  output logic              timeout_err,
  output logic [RET_W-1:0]  retired
);

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    HALTED = 3'd3,
    ERR    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RET_W-1:0]    retired_q, retired_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                commit_c;
  logic                to_hit_c;

  // Timeout fires only when enabled and the wait counter has reached the limit.
  assign to_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= PC_INIT;
      instr_q   <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  // Next-state, PC/counter update and commit decision.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    commit_c  = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (ihit) begin
          instr_d = imemload;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (to_hit_c) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXEC: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (dreq_rd || dreq_wr) begin
          rd_d    = dreq_rd;
          wr_d    = dreq_wr;
          cnt_d   = '0;
          state_d = MEM;
        end else begin
          commit_c = 1'b1;
          pc_d     = next_pc;
          cnt_d    = '0;
          state_d  = FETCH;
        end
      end
      MEM: begin
        if (dhit) begin
          commit_c = 1'b1;
          pc_d     = next_pc;
          cnt_d    = '0;
          state_d  = FETCH;
        end else if (to_hit_c) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALTED: state_d = HALTED;
      ERR:    state_d = ERR;
      default: state_d = FETCH;
    endcase

    retired_d = retired_q + (commit_c ? RET_W'(1) : RET_W'(0));
  end

  // Output decode; write wins over read when both were requested.
  assign imemREN     = (state_q == FETCH);
  assign imemaddr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == EXEC) || (state_q == MEM);
  assign dmemWEN     = (state_q == MEM) && wr_q;
  assign dmemREN     = (state_q == MEM) && rd_q && !wr_q;
  assign commit      = commit_c;
  assign halt        = (state_q == HALTED) || (state_q == ERR);
  assign timeout_err = (state_q == ERR);
  assign retired     = retired_q;

endmodule

// File: tb/tb_mem_seq_unit.sv
// Directed bench for mem_seq_unit: sequencing, memory phases, halt, timeout
// and mid-operation reset.
`timescale 1ns/1ps
module tb_mem_seq_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dreq_rd, dreq_wr, halt_req;
  logic [31:0] next_pc;
  logic        dhit;
  logic        dmemREN, dmemWEN, commit, halt, timeout_err;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  mem_seq_unit #(
    .ADDR_W (32),
    .PC_INIT(32'h40),
    .TIMEOUT(4),
    .CNT_W  (8),
    .RET_W  (32)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr),
    .instr_valid(instr_valid), .dreq_rd(dreq_rd), .dreq_wr(dreq_wr),
    .halt_req(halt_req), .next_pc(next_pc), .dhit(dhit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .commit(commit), .halt(halt),
    .timeout_err(timeout_err), .retired(retired)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; dreq_rd = 1'b0; dreq_wr = 1'b0;
    halt_req = 1'b0; next_pc = '0; dhit = 1'b0;
    @(negedge CLK);
    step();
    #1;
    chk("rst_addr", imemaddr, 32'h40);
    chk("rst_ren", 32'(imemREN), 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    RST = 1'b0;

    // Back-to-back non-memory instructions: 2 cycles each.
    for (int k = 0; k < 3; k++) begin
      ihit = 1'b1; imemload = 32'h1000 + 32'(k);
      #1;
      chk("seq_addr", imemaddr, 32'h40 + 32'(4 * k));
      chk("seq_fetch_commit", 32'(commit), 32'd0);
      step();
      next_pc = 32'h44 + 32'(4 * k);
      #1;
      chk("seq_instr", instr, 32'h1000 + 32'(k));
      chk("seq_exec_commit", 32'(commit), 32'd1);
      chk("seq_valid", 32'(instr_valid), 32'd1);
      step();
    end
    #1;
    chk("seq_retired", retired, 32'd3);
    chk("seq_addr_end", imemaddr, 32'h4C);

    // Load with dhit arriving on the fourth MEM cycle.
    ihit = 1'b1; imemload = 32'hABCD0001;
    step();
    ihit = 1'b0; dreq_rd = 1'b1;
    #1;
    chk("ld_exec_commit", 32'(commit), 32'd0);
    step();
    dreq_rd = 1'b0; ihit = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin dhit = 1'b1; next_pc = 32'h50; end
      #1;
      chk("ld_dren", 32'(dmemREN), 32'd1);
      chk("ld_dwen", 32'(dmemWEN), 32'd0);
      chk("ld_iren", 32'(imemREN), 32'd0);
      chk("ld_instr", instr, 32'hABCD0001);
      chk("ld_commit", 32'(commit), (c == 3) ? 32'd1 : 32'd0);
      step();
    end
    dhit = 1'b0;
    #1;
    chk("ld_addr", imemaddr, 32'h50);
    chk("ld_retired", retired, 32'd4);
    chk("ld_dren_off", 32'(dmemREN), 32'd0);

    // Read and write together: write wins.
    ihit = 1'b1; imemload = 32'h3;
    step();
    ihit = 1'b0; dreq_rd = 1'b1; dreq_wr = 1'b1;
    step();
    dreq_rd = 1'b0; dreq_wr = 1'b0; dhit = 1'b1; next_pc = 32'h54;
    #1;
    chk("rw_dwen", 32'(dmemWEN), 32'd1);
    chk("rw_dren", 32'(dmemREN), 32'd0);
    chk("rw_commit", 32'(commit), 32'd1);
    step();
    dhit = 1'b0;
    #1;
    chk("rw_addr", imemaddr, 32'h54);
    chk("rw_retired", retired, 32'd5);

    // Fetch hit on the fifth cycle beats the timeout.
    ihit = 1'b0;
    for (int c = 0; c < 4; c++) step();
    ihit = 1'b1; imemload = 32'h5;
    #1;
    chk("late_terr_pre", 32'(timeout_err), 32'd0);
    step();
    ihit = 1'b0; halt_req = 1'b1; next_pc = 32'h99;
    #1;
    chk("late_valid", 32'(instr_valid), 32'd1);
    chk("late_terr", 32'(timeout_err), 32'd0);
    chk("halt_exec_commit", 32'(commit), 32'd0);
    step();
    halt_req = 1'b0;

    // Halted: absorbing, ihit pulses ignored.
    for (int c = 0; c < 3; c++) begin
      ihit = (c != 1);
      #1;
      chk("halt_flag", 32'(halt), 32'd1);
      chk("halt_iren", 32'(imemREN), 32'd0);
      chk("halt_commit", 32'(commit), 32'd0);
      step();
    end
    ihit = 1'b0;
    #1;
    chk("halt_addr", imemaddr, 32'h54);
    chk("halt_retired", retired, 32'd5);
    chk("halt_terr", 32'(timeout_err), 32'd0);

    // Fetch timeout after five miss cycles.
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("rst2_halt", 32'(halt), 32'd0);
    chk("rst2_retired", retired, 32'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("to_iren", 32'(imemREN), 32'd1);
      chk("to_terr_pre", 32'(timeout_err), 32'd0);
      step();
    end
    #1;
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_halt", 32'(halt), 32'd1);
    chk("to_iren_off", 32'(imemREN), 32'd0);
    ihit = 1'b1;
    step();
    #1;
    chk("to_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a MEM phase abandons the access.
    RST = 1'b1;
    step();
    RST = 1'b0; ihit = 1'b1; imemload = 32'h77;
    step();
    ihit = 1'b0; dreq_rd = 1'b1;
    step();
    dreq_rd = 1'b0;
    #1;
    chk("mr_dren", 32'(dmemREN), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("mr_iren", 32'(imemREN), 32'd1);
    chk("mr_addr", imemaddr, 32'h40);
    chk("mr_retired", retired, 32'd0);
    chk("mr_dren_off", 32'(dmemREN), 32'd0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_terr", 32'(timeout_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_seq_unit.md
# mem_seq_unit

Parametrised multi-cycle fetch/memory sequencer that replaces free-running PC enable gating with an explicit state machine. It owns the PC register and serialises each instruction into fetch, execute and optional data-memory phases. It emits a single `commit` pulse per retired instruction to gate register-file writes, and detects memory timeouts and halts. It sits between the control unit / register file logic and the `datapath_cache_if` port of the datapath.

## Interface
Parameters:
- `ADDR_W`, 32: PC and address width.
- `PC_INIT`, 0: PC value loaded on reset.
- `TIMEOUT`, 255: maximum wait cycles in FETCH or MEM before error; 0 disables the timeout.
- `CNT_W`, 8: width of the wait counter; must hold `TIMEOUT`.
- `RET_W`, 32: width of the retired-instruction counter.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ihit`  in  1  instruction memory hit.
- `imemload`  in  32  instruction data.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  ADDR_W  fetch address (= PC).
- `instr`  out  32  latched instruction, stable through EXEC and MEM.
- `instr_valid`  out  1  high in EXEC and MEM.
- `dreq_rd`  in  1  decoded load; sampled in EXEC.
- `dreq_wr`  in  1  decoded store; sampled in EXEC.
- `halt_req`  in  1  decoded halt; sampled in EXEC.
- `next_pc`  in  ADDR_W  next PC from branch/jump logic; sampled on commit.
- `dhit`  in  1  data memory hit.
- `dmemREN`  out  1  data read request.
- `dmemWEN`  out  1  data write request.
- `commit`  out  1  one-cycle retire pulse (register-file write gate).
- `halt`  out  1  sticky halt indication.
- `timeout_err`  out  1  sticky timeout flag.
- `retired`  out  RET_W  count of committed instructions.

## Operation
- States: FETCH, EXEC, MEM, HALTED, ERR.
- Reset (`RST`=1 at an edge):
  - State is FETCH, PC is `PC_INIT`, `instr` is 0, wait counter is 0, `retired` is 0, latched read/write flags are 0.
  - `timeout_err` and `halt` are 0.
  - Reset mid-operation abandons any pending request with no commit.
- FETCH:
  - `imemREN`=1, `imemaddr`=PC.
  - On `ihit`: latch `imemload` into `instr` and go to EXEC. `dhit` is ignored.
- EXEC (exactly one cycle):
  - If `halt_req`: go to HALTED. No commit; PC is unchanged.
  - Else if `dreq_rd` or `dreq_wr`: latch both flags and go to MEM. If both are set, write wins and the read is dropped.
  - Else: `commit`=1, PC←`next_pc`, go to FETCH.
- MEM:
  - `dmemWEN`=latched write flag; `dmemREN`=latched read flag and not write.
  - On `dhit`: `commit`=1, PC←`next_pc`, go to FETCH. `ihit` is ignored.
- Wait counter:
  - Cleared on entry to FETCH and to MEM, and on any hit.
  - Increments each FETCH or MEM cycle without the relevant hit.
  - If `TIMEOUT`≠0 and the counter equals `TIMEOUT` in a no-hit cycle: go to ERR and set `timeout_err`=1.
  - A hit in the same cycle the counter reaches `TIMEOUT` takes priority over the timeout.
- HALTED and ERR are absorbing until `RST`. Both drive `halt`=1, all requests 0, and `commit`=0.
- `retired` increments by 1 on each `commit` and wraps modulo 2^RET_W.
- `commit` is combinational from state and `dhit` (in MEM). The PC update and counter increment take effect at the following edge.
- `imemREN`, `dmemREN` and `dmemWEN` are never high simultaneously.

## Timing
- Non-memory instruction with immediate `ihit`:
  - FETCH at cycle n, EXEC with commit at n+1, next FETCH at n+2.
  - Minimum 2 cycles per instruction.
- Memory instruction with immediate hits:
  - FETCH at n, EXEC at n+1, MEM with `dhit` and commit at n+2, FETCH at n+3.
  - Minimum 3 cycles per instruction.
- Each miss cycle adds one cycle.
- The new PC appears on `imemaddr` in the cycle after commit.
- `halt` rises in the cycle after EXEC sees `halt_req`.
- `timeout_err` rises in the cycle after the counter reaches `TIMEOUT`.

## Test plan
- Reset with `PC_INIT`=0x40, `ihit`=1, no data ops, `next_pc`=PC+4 → `imemaddr` sequence 0x40, 0x44, 0x48, one commit every 2 cycles, `retired`=3 after 6 cycles.
- Load with `dhit` delayed 3 cycles → `dmemREN` held 4 cycles, single commit on the hit cycle, `instr` stable throughout, `imemREN`=0 during MEM.
- `dreq_rd`=`dreq_wr`=1 in EXEC → only `dmemWEN`=1 in MEM.
- `halt_req` in EXEC → `halt`=1 the next cycle and stays 1; PC frozen; `retired` unchanged; `ihit` pulses ignored.
- `TIMEOUT`=4 with `ihit` held 0 → `timeout_err`=1 and `halt`=1 after 5 FETCH cycles. Repeat with `ihit` arriving on the 5th cycle → normal EXEC, no error.
- `RST` asserted mid-MEM → next cycle in FETCH with PC=`PC_INIT`, no commit, `retired`=0, flags cleared.
